peripheral_bus_master: RTL and testbench
========================================

PERIPHERAL_BUS_MASTER -- requirements
Module: peripheral_bus_master

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 8'h00, value wb_adr_i[23:16] must equal for this block to respond.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, number of busy cycles tolerated before an error response.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-006 wb_sel_i  input  4  byte lanes; wb_adr_i  input  24  byte address; wb_data_i  input  32  write data.
REQ-007 wb_ack_o, wb_error_o  output  1 each  one-cycle completion pulses; wb_data_o  output  32  read data.
REQ-008 peripheralEnable, peripheralBus_we, peripheralBus_oe  output  1 each  access qualifiers.
REQ-009 peripheralBus_address  output  16; peripheralBus_byteSelect  output  4; peripheralBus_dataWrite  output  32.
REQ-010 peripheralBus_busy  input  1  stall; peripheralBus_dataRead  input  32; requestOutput  input  1  read data valid.

Function
REQ-011 SHALL implement states IDLE, ACCESS, RESPOND.
REQ-012 IDLE: on wb_cyc_i & wb_stb_i & (wb_adr_i[23:16]==BASE_ADDRESS), SHALL latch wb_adr_i[15:0], wb_sel_i, wb_data_i and wb_we_i, clear the timeout counter and move to ACCESS; on an address mismatch, SHALL stay in IDLE and never respond.
REQ-013 ACCESS: SHALL drive peripheralEnable=1 and either peripheralBus_we=1 (write) or peripheralBus_oe=1 (read), never both, and drive the latched address, byteSelect and dataWrite values.
REQ-014 ACCESS with busy=0, write: SHALL complete with ack and move to RESPOND.
REQ-015 ACCESS with busy=0, read, requestOutput=1: SHALL capture peripheralBus_dataRead into wb_data_o, complete with ack, and move to RESPOND.
REQ-016 ACCESS with busy=0, read, requestOutput=0: SHALL set wb_data_o=32'hFFFFFFFF, complete with error, and move to RESPOND.
REQ-017 ACCESS with busy=1: SHALL stay in ACCESS and increment the counter; when the counter reaches TIMEOUT_CYCLES-1 while busy is still 1, SHALL complete with error and wb_data_o=32'hFFFFFFFF.
REQ-018 RESPOND: SHALL assert exactly one of wb_ack_o or wb_error_o for one cycle, hold wb_data_o, and return to IDLE.
REQ-019 Latency: with no busy, the response pulse SHALL occur 2 cycles after the edge that samples the strobe; each busy cycle SHALL add 1 cycle.
REQ-020 Outside ACCESS: peripheralEnable, peripheralBus_we and peripheralBus_oe SHALL be 0; address, byteSelect and dataWrite SHALL hold their last latched values.
REQ-021 wb_cyc_i falling in ACCESS or RESPOND SHALL abort: next state IDLE, no ack or error pulse, bus qualifiers low from the next cycle.
REQ-022 A new request SHALL NOT be accepted in the RESPOND cycle; back-to-back transfers are therefore spaced 3 cycles minimum.
REQ-023 byteSelect SHALL pass through unchanged, including 4'b0000.
REQ-024 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL NOT wrap.

Reset
REQ-025 rst SHALL force state IDLE, all outputs 0 (wb_data_o, address, byteSelect and dataWrite included) and the counter to 0 on the same edge, including during an in-flight access.

Structure
REQ-026 Package peripheral_bus_pkg SHALL hold the state enum, the 16-bit peripheral address width, the 32-bit data width and the 32'hFFFFFFFF error-data constant.
REQ-027 The timeout counter SHALL be the single sub-module peripheral_bus_timeout (clear, count enable, expired flag).

Verification
REQ-028 Write 0x0000_00A5 to adr 0x000004, sel 4'hF, busy=0 -> ACCESS with peripheralBus_we=1 and address 0x0004; ack 2 cycles after strobe.
REQ-029 Read adr 0x000080, dataRead=0x1234_5678, requestOutput=1 -> wb_data_o=0x12345678 and ack.
REQ-030 Read with requestOutput=0 -> wb_error_o pulse and wb_data_o=0xFFFFFFFF.
REQ-031 busy held for 3 cycles, then released -> ack 5 cycles after strobe; busy held for 20 cycles with TIMEOUT_CYCLES=16 -> error on the 16th busy cycle.
REQ-032 wb_cyc_i dropped during ACCESS -> no ack, peripheralEnable=0 on the next cycle; a request to adr 0x010004 with BASE_ADDRESS=0 -> no bus activity.
REQ-033 rst asserted mid-ACCESS -> all outputs 0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the Wishbone-to-peripheral bus bridge.
package peripheral_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

endpackage

// File: rtl/peripheral_bus_master_if.sv
// Wishbone slave side plus peripheral bus side of the bridge, bundled.
interface peripheral_bus_master_if;
   import peripheral_bus_pkg::*;

   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [3:0]        wb_sel_i;
   logic [23:0]       wb_adr_i;
   logic [DATA_W-1:0] wb_data_i;
   logic              wb_ack_o;
   logic              wb_error_o;
   logic [DATA_W-1:0] wb_data_o;

   logic              peripheralEnable;
   logic              peripheralBus_we;
   logic              peripheralBus_oe;
   logic [ADDR_W-1:0] peripheralBus_address;
   logic [3:0]        peripheralBus_byteSelect;
   logic [DATA_W-1:0] peripheralBus_dataWrite;
   logic              peripheralBus_busy;
   logic [DATA_W-1:0] peripheralBus_dataRead;
   logic              requestOutput;

   // The bridge itself: Wishbone requests in, peripheral accesses out.
   modport master (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
      output wb_ack_o, wb_error_o, wb_data_o,
      output peripheralEnable, peripheralBus_we, peripheralBus_oe,
      output peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
      input  peripheralBus_busy, peripheralBus_dataRead, requestOutput
   );

   modport slave (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
      input  wb_ack_o, wb_error_o, wb_data_o,
      input  peripheralEnable, peripheralBus_we, peripheralBus_oe,
      input  peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
      output peripheralBus_busy, peripheralBus_dataRead, requestOutput
   );

endinterface

// File: rtl/peripheral_bus_timeout.sv
// Saturating busy-cycle counter; expired marks the last tolerated busy cycle.
module peripheral_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (count_en && count != TOP)
         count <= count + CW'(1);
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave that turns one request into one peripheral bus access.
module peripheral_bus_master
   import peripheral_bus_pkg::*;
#(
   parameter logic [7:0] BASE_ADDRESS   = 8'h00,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input logic                    clk,
   input logic                    rst,
   peripheral_bus_master_if.master bus
);

   state_t            state, state_nxt;
   logic              we_q;
   logic [ADDR_W-1:0] adr_q;
   logic [3:0]        sel_q;
   logic [DATA_W-1:0] dwr_q;
   logic [DATA_W-1:0] rdata_q;
   logic              resp_ok_q, resp_err_q;
   logic              hit, done_ok, done_err;
   logic              tmr_clr, tmr_en, tmr_exp;

   assign hit = bus.wb_cyc_i & bus.wb_stb_i & (bus.wb_adr_i[23:16] == BASE_ADDRESS);

   peripheral_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clr),
      .count_en (tmr_en),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      done_ok   = 1'b0;
      done_err  = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               state_nxt = ACCESS;
               tmr_clr   = 1'b1;
            end
         end
         ACCESS: begin
            // An abort wins over any completion seen on the same edge.
            if (!bus.wb_cyc_i) begin
               state_nxt = IDLE;
            end else if (!bus.peripheralBus_busy) begin
               state_nxt = RESPOND;
               if (we_q || bus.requestOutput) done_ok  = 1'b1;
               else                           done_err = 1'b1;
            end else if (tmr_exp) begin
               state_nxt = RESPOND;
               done_err  = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         RESPOND: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         adr_q      <= '0;
         sel_q      <= '0;
         dwr_q      <= '0;
         rdata_q    <= '0;
         resp_ok_q  <= 1'b0;
         resp_err_q <= 1'b0;
      end else begin
         if (state == IDLE && hit) begin
            we_q  <= bus.wb_we_i;
            adr_q <= bus.wb_adr_i[ADDR_W-1:0];
            sel_q <= bus.wb_sel_i;
            dwr_q <= bus.wb_data_i;
         end
         if (done_ok && !we_q) rdata_q <= bus.peripheralBus_dataRead;
         if (done_err)         rdata_q <= ERR_DATA;
         resp_ok_q  <= done_ok;
         resp_err_q <= done_err;
      end
   end

   // Gating with cyc suppresses the pulse if the master gives up in RESPOND.
   assign bus.wb_ack_o   = (state == RESPOND) & resp_ok_q  & bus.wb_cyc_i;
   assign bus.wb_error_o = (state == RESPOND) & resp_err_q & bus.wb_cyc_i;
   assign bus.wb_data_o  = rdata_q;

   assign bus.peripheralEnable         = (state == ACCESS);
   assign bus.peripheralBus_we         = (state == ACCESS) &  we_q;
   assign bus.peripheralBus_oe         = (state == ACCESS) & ~we_q;
   assign bus.peripheralBus_address    = adr_q;
   assign bus.peripheralBus_byteSelect = sel_q;
   assign bus.peripheralBus_dataWrite  = dwr_q;

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Directed table, corner-case sequences and random transfers against a transfer-level model.
module tb_peripheral_bus_master;
   import peripheral_bus_pkg::*;

   localparam logic [7:0] BASE = 8'h00;
   localparam int         TMO  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   peripheral_bus_master_if bus ();

   peripheral_bus_master #(.BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [3:0]  sel;
      logic [31:0] wd;
      int          busy;
      logic        ro;
      logic [31:0] rd;
      logic        ack;
      logic        err;
      logic [31:0] dat;
      int          lat;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_sel_i = '0; bus.wb_adr_i = '0; bus.wb_data_i = '0;
      bus.peripheralBus_busy = 1'b0; bus.peripheralBus_dataRead = '0;
      bus.requestOutput = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ack"}, 32'(bus.wb_ack_o), 32'd0);
      chk({tag, ".err"}, 32'(bus.wb_error_o), 32'd0);
      chk({tag, ".rdata"}, bus.wb_data_o, 32'd0);
      chk({tag, ".en"}, 32'(bus.peripheralEnable), 32'd0);
      chk({tag, ".we"}, 32'(bus.peripheralBus_we), 32'd0);
      chk({tag, ".oe"}, 32'(bus.peripheralBus_oe), 32'd0);
      chk({tag, ".addr"}, 32'(bus.peripheralBus_address), 32'd0);
      chk({tag, ".sel"}, 32'(bus.peripheralBus_byteSelect), 32'd0);
      chk({tag, ".dwr"}, bus.peripheralBus_dataWrite, 32'd0);
   endtask

   // Issue one transfer; lat is the edge count from the strobe-sampling edge
   // to the edge at which the master samples the response.
   task automatic run_xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd, input int busy_n, input logic ro,
                           input logic [31:0] rd, output logic ack, output logic err,
                           output logic [31:0] dout, output int lat);
      int rem, n;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
      bus.wb_adr_i = {BASE, adr}; bus.wb_sel_i = sel; bus.wb_data_i = wd;
      bus.peripheralBus_busy = 1'b0; bus.requestOutput = 1'b0;
      @(posedge clk); #1;
      chk("access.en", 32'(bus.peripheralEnable), 32'd1);
      chk("access.we", 32'(bus.peripheralBus_we), 32'(we));
      chk("access.oe", 32'(bus.peripheralBus_oe), 32'(!we));
      chk("access.addr", 32'(bus.peripheralBus_address), 32'(adr));
      chk("access.sel", 32'(bus.peripheralBus_byteSelect), 32'(sel));
      chk("access.dwr", bus.peripheralBus_dataWrite, wd);
      rem = busy_n;
      bus.peripheralBus_busy = (rem > 0);
      bus.peripheralBus_dataRead = rd;
      bus.requestOutput = ro;
      n = 0; ack = 1'b0; err = 1'b0;
      while (n < 40 && !(ack || err)) begin
         @(posedge clk); #1;
         n++;
         if (rem > 0) rem--;
         ack = bus.wb_ack_o;
         err = bus.wb_error_o;
         bus.peripheralBus_busy = (rem > 0);
      end
      dout = bus.wb_data_o;
      lat  = n + 1;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.peripheralBus_busy = 1'b0;
      @(posedge clk); #1;
      chk("after.ack", 32'(bus.wb_ack_o | bus.wb_error_o), 32'd0);
      chk("after.en", 32'(bus.peripheralEnable), 32'd0);
      chk("after.addr_hold", 32'(bus.peripheralBus_address), 32'(adr));
   endtask

   logic        r_ack, r_err;
   logic [31:0] r_dat, mdata;
   int          r_lat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 16'h0004, 4'hF, 32'h0000_00A5, 0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 2};
      tbl[1] = '{1'b0, 16'h0080, 4'hF, 32'h0,         0,  1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 2};
      tbl[2] = '{1'b1, 16'hFFFC, 4'h0, 32'hDEAD_BEEF, 3,  1'b0, 32'h0,         1'b1, 1'b0, 32'h1234_5678, 5};
      tbl[3] = '{1'b0, 16'h0010, 4'h3, 32'h0,         0,  1'b0, 32'h5555_5555, 1'b0, 1'b1, 32'hFFFF_FFFF, 2};
      tbl[4] = '{1'b0, 16'h0020, 4'hC, 32'h0,         20, 1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 32'hFFFF_FFFF, 17};
      tbl[5] = '{1'b0, 16'h0030, 4'h1, 32'h0,         15, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D, 17};
      tbl[6] = '{1'b1, 16'h0040, 4'h5, 32'h1122_3344, 16, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 17};

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, tbl[i].busy, tbl[i].ro,
                  tbl[i].rd, r_ack, r_err, r_dat, r_lat);
         chk($sformatf("tbl%0d.ack", i), 32'(r_ack), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d.err", i), 32'(r_err), 32'(tbl[i].err));
         chk($sformatf("tbl%0d.data", i), r_dat, tbl[i].dat);
         chk($sformatf("tbl%0d.lat", i), 32'(r_lat), 32'(tbl[i].lat));
      end
      mdata = 32'hFFFF_FFFF;

      // Strobe held high: acks land every third edge since RESPOND refuses new work.
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_adr_i = 24'h000100; bus.wb_sel_i = 4'hF; bus.wb_data_i = 32'h5A5A_5A5A;
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b.ack%0d", i), 32'(bus.wb_ack_o), 32'(i == 1 || i == 4 || i == 7));
      end
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(posedge clk); #1;
      chk("b2b.abort_en", 32'(bus.peripheralEnable), 32'd0);

      // Abort in ACCESS.
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 24'h000200;
      bus.peripheralBus_busy = 1'b1;
      @(posedge clk); #1;
      chk("abort.en_before", 32'(bus.peripheralEnable), 32'd1);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(posedge clk); #1;
      chk("abort.en_after", 32'(bus.peripheralEnable), 32'd0);
      chk("abort.oe_after", 32'(bus.peripheralBus_oe), 32'd0);
      bus.peripheralBus_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort.no_resp", 32'(bus.wb_ack_o | bus.wb_error_o), 32'd0);
      end

      // Abort in RESPOND: cyc drops before the master samples the pulse.
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 24'h000300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      #1;
      chk("respond_abort.ack", 32'(bus.wb_ack_o), 32'd0);
      @(posedge clk); #1;
      chk("respond_abort.ack_next", 32'(bus.wb_ack_o), 32'd0);

      // Other block's address range.
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 24'h010004;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("miss.en", 32'(bus.peripheralEnable), 32'd0);
         chk("miss.resp", 32'(bus.wb_ack_o | bus.wb_error_o), 32'd0);
      end
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(posedge clk); #1;

      // Reset while the peripheral is stalling.
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 24'h00ABCD;
      bus.wb_sel_i = 4'hA; bus.wb_data_i = 32'hCAFE_0001; bus.peripheralBus_busy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst.en_before", 32'(bus.peripheralEnable), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("midrst");
      rst = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      mdata = 32'h0;

      for (int i = 0; i < 40; i++) begin
         logic        we, ro, e_ack, e_err;
         logic [15:0] adr;
         logic [3:0]  sel;
         logic [31:0] wd, rd, e_dat;
         int          busy_n, e_lat;
         we  = 1'($urandom);
         ro  = 1'($urandom);
         adr = 16'($urandom);
         sel = 4'($urandom);
         wd  = $urandom;
         rd  = $urandom;
         busy_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
         if (busy_n >= TMO) begin
            e_ack = 1'b0; e_err = 1'b1; e_dat = 32'hFFFF_FFFF; e_lat = TMO + 1;
         end else if (we) begin
            e_ack = 1'b1; e_err = 1'b0; e_dat = mdata; e_lat = busy_n + 2;
         end else if (ro) begin
            e_ack = 1'b1; e_err = 1'b0; e_dat = rd; e_lat = busy_n + 2;
         end else begin
            e_ack = 1'b0; e_err = 1'b1; e_dat = 32'hFFFF_FFFF; e_lat = busy_n + 2;
         end
         mdata = e_dat;
         run_xfer(we, adr, sel, wd, busy_n, ro, rd, r_ack, r_err, r_dat, r_lat);
         chk($sformatf("rnd%0d.ack", i), 32'(r_ack), 32'(e_ack));
         chk($sformatf("rnd%0d.err", i), 32'(r_err), 32'(e_err));
         chk($sformatf("rnd%0d.data", i), r_dat, e_dat);
         chk($sformatf("rnd%0d.lat", i), 32'(r_lat), 32'(e_lat));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
